spi_ram_ctrl: RTL and testbench
===============================

# spi_ram_ctrl

Command controller and two-port arbiter between the SPI slave and the single-port synchronous RAM.
- Decodes each 10-bit word from the SPI slave (2-bit opcode + 8-bit payload) into RAM address updates, writes and reads, and returns read data on tx_data/tx_valid.
- Shares the RAM with a second requester (host/debug port) under round-robin arbitration.
- Sits between the SPI slave FSM and the RAM; it is the RAM's only master.

## Interface
- ADDR_SIZE, 8: RAM address width; equals payload width.
- TX_HOLD, 9: cycles tx_valid stays high per read-data response.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rx_data  in  10  SPI word; [9:8] opcode, [7:0] payload.
- rx_valid  in  1  level from SPI slave; may stay high many cycles.
- tx_data  out  8  read data to SPI slave.
- tx_valid  out  1  tx_data valid.
- host_req  in  1  host access request; held until granted.
- host_we  in  1  1 = write, 0 = read; stable while host_req high.
- host_addr  in  ADDR_SIZE  host address.
- host_wdata  in  8  host write data.
- host_gnt  out  1  one-cycle pulse; access issued this cycle.
- host_rdata  out  8  host read data.
- host_rvalid  out  1  one-cycle pulse with host_rdata.
- mem_en, mem_we  out  1 each  RAM enable / write enable.
- mem_addr  out  ADDR_SIZE  RAM address.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data; valid the cycle after mem_en with mem_we=0.
- spi_err  out  1  sticky; set when an SPI command is dropped.

## Operation
- Command capture: rising edge of rx_valid (registered previous value, 0 at reset) captures rx_data once.
- Opcodes:
  - 00: wr_addr <= payload.
  - 01: RAM write mem[wr_addr] <= payload.
  - 10: rd_addr <= payload.
  - 11: RAM read mem[rd_addr]; payload ignored.
- Opcodes 00/10 complete in the capture cycle with no RAM access.
- wr_addr and rd_addr reset to 0 and never auto-increment.
- SPI FSM:
  - S_IDLE: an 01/11 capture -> S_PEND.
  - S_PEND: on SPI grant, 01 -> S_IDLE; 11 -> S_RDWAIT.
  - S_RDWAIT: 1 cycle -> S_TX.
  - S_TX: tx_valid high for TX_HOLD cycles -> S_IDLE.
- Capture while in S_PEND or S_RDWAIT: command dropped, spi_err set (cleared only by reset).
- Capture while in S_TX: tx_valid clears the next cycle and the command is processed as from S_IDLE.
- Arbiter:
  - Requesters are SPI (in S_PEND) and host (host_req).
  - At most one grant per cycle; one access may issue every cycle.
  - On conflict, grant the requester not granted last; last_gnt resets to host, so SPI wins the first conflict.
  - A sole requester is always granted.
- Read data is routed by an owner tag pipelined alongside the access.

## Timing
- Grant decided combinationally in cycle C0; mem_* and host_gnt registered, active in C1.
- RAM read data present in C2, registered at end of C2.
- SPI read: tx_data/tx_valid high from C3.
- Host read: host_rdata/host_rvalid from C3; host_rvalid high for 1 cycle.
- Uncontended SPI latency: rx_valid rising edge registered at cycle 0; mem_en in cycle 2; tx_valid in cycle 4.
- Writes take effect at end of C1.
- Reset values: tx_data 0, tx_valid 0, host_gnt 0, host_rvalid 0, host_rdata 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, spi_err 0.
- Reset also forces FSM to S_IDLE, last_gnt to host, and the rx_valid history to 0.
- Reset mid-read: in-flight data discarded; no tx_valid or host_rvalid after reset.
- host_req deasserted before grant: no access, no error.

## Structure
- Shared package spi_ram_pkg: opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11; SPI FSM state encodings; owner tag constants OWN_SPI/OWN_HOST.
- Sub-module ram_rr_arbiter: 2-requester round-robin with last_gnt register; outputs a one-hot grant.

## Test plan
- SPI writes 0x0_AA (addr AA), then 0x1_5C -> single mem write AA<=5C, mem_en/mem_we in cycle 2 after the second edge; no tx_valid.
- SPI 0x2_AA then 0x3_00 with RAM holding 5C -> tx_data=0x5C, tx_valid high exactly 9 cycles starting cycle 4.
- host_req read and SPI 0x3_00 pending in the same cycle, first after reset -> SPI granted first, host granted next cycle, tx_valid cycle 4, host_rvalid one cycle later.
- Continuous host_req writes plus repeated SPI 01 commands -> grants alternate; neither requester waits more than 1 cycle.
- rx_valid rising while in S_PEND (host hogging via conflict) -> second command dropped, spi_err=1 and stays 1.
- rst_n low in C2 of an SPI read -> tx_valid never asserts, all outputs 0; a subsequent 0x3_00 reads rd_addr=0.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-to-RAM command controller and its arbiter.
package spi_ram_pkg;

    localparam int ADDR_SIZE_DEF = 8;
    localparam int TX_HOLD_DEF   = 9;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PEND   = 2'd1,
        S_RDWAIT = 2'd2,
        S_TX     = 2'd3
    } spi_state_e;

    // Owner tags double as request/grant bit positions in the arbiter.
    localparam logic OWN_SPI  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

endpackage

// File: rtl/ram_rr_arbiter.sv
// Two-requester round-robin arbiter: a sole requester always wins, a conflict
// goes to whoever was not granted last. Grant is one-hot and combinational.
module ram_rr_arbiter
    import spi_ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_gnt_q;
    logic last_gnt_d;

    // Grant selection and last-winner tracking.
    always_comb begin
        gnt        = req;
        last_gnt_d = last_gnt_q;
        if (req == 2'b11) begin
            gnt = (last_gnt_q == OWN_HOST) ? 2'b01 : 2'b10;
        end
        if (gnt[OWN_SPI]) begin
            last_gnt_d = OWN_SPI;
        end else if (gnt[OWN_HOST]) begin
            last_gnt_d = OWN_HOST;
        end
    end

    // Last-winner register; starts at host so SPI takes the first conflict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_q <= OWN_HOST;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI command decoder and RAM master. SPI words and a host port share the
// single-port RAM; read data is steered back by an owner tag that travels
// with each access.
//
// state    | meaning
// S_IDLE   | no SPI RAM access outstanding
// S_PEND   | SPI write/read waiting for an arbiter grant
// S_RDWAIT | SPI read on the RAM port this cycle
// S_TX     | read data returning, then held on tx_data for TX_HOLD cycles
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int TX_HOLD   = TX_HOLD_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [7:0]           host_wdata,
    output logic                 host_gnt,
    output logic [7:0]           host_rdata,
    output logic                 host_rvalid,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    output logic                 spi_err
);

    localparam int CNT_W = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;

    spi_state_e           state_q, state_d;
    logic                 rx_valid_q, rx_hist_q;
    logic [9:0]           rx_data_q;
    logic [9:0]           cmd_q, cmd_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic                 spi_err_q, spi_err_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic                 mem_en_q, mem_en_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]           mem_wdata_q, mem_wdata_d;
    logic                 host_gnt_q, host_gnt_d;
    logic                 own_c1_q, own_c1_d;
    logic                 rd_c2_q, rd_c2_d;
    logic                 own_c2_q, own_c2_d;
    logic [7:0]           host_rdata_q, host_rdata_d;
    logic                 host_rvalid_q, host_rvalid_d;

    logic                 capture;
    logic                 spi_rdata_vld;
    logic [1:0]           arb_req;
    logic [1:0]           arb_gnt;

    // rx_valid is a level; one command is taken per rising edge of its registered copy.
    assign capture          = rx_valid_q & ~rx_hist_q;
    assign spi_rdata_vld    = rd_c2_q & (own_c2_q == OWN_SPI);
    assign arb_req[OWN_SPI]  = (state_q == S_PEND);
    assign arb_req[OWN_HOST] = host_req;

    ram_rr_arbiter u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (arb_req),
        .gnt   (arb_gnt)
    );

    // SPI FSM: command decode, drop detection and the tx hold down-counter.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        spi_err_d  = spi_err_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_cnt_d   = tx_cnt_q;
        case (state_q)
            S_PEND: begin
                if (arb_gnt[OWN_SPI]) begin
                    state_d = (cmd_q[9:8] == OP_RD_DATA) ? S_RDWAIT : S_IDLE;
                end
            end
            S_RDWAIT: state_d = S_TX;
            S_TX: begin
                if (spi_rdata_vld) begin
                    tx_data_d  = mem_rdata;
                    tx_valid_d = 1'b1;
                    tx_cnt_d   = CNT_W'(TX_HOLD - 1);
                end else if (tx_valid_q) begin
                    if (tx_cnt_q == '0) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        tx_cnt_d = tx_cnt_q - CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
        if (capture) begin
            if (state_q == S_PEND || state_q == S_RDWAIT) begin
                spi_err_d = 1'b1;
            end else begin
                // A new word during S_TX cuts the response short and is decoded as from idle.
                tx_valid_d = 1'b0;
                state_d    = S_IDLE;
                case (rx_data_q[9:8])
                    OP_WR_ADDR: wr_addr_d = ADDR_SIZE'(rx_data_q[7:0]);
                    OP_RD_ADDR: rd_addr_d = ADDR_SIZE'(rx_data_q[7:0]);
                    default: begin
                        cmd_d   = rx_data_q;
                        state_d = S_PEND;
                    end
                endcase
            end
        end
    end

    // RAM issue from the granted requester and owner-tagged read data return.
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        own_c1_d    = own_c1_q;
        host_gnt_d  = arb_gnt[OWN_HOST];
        if (arb_gnt[OWN_SPI]) begin
            mem_en_d    = 1'b1;
            mem_we_d    = (cmd_q[9:8] == OP_WR_DATA);
            mem_addr_d  = mem_we_d ? wr_addr_q : rd_addr_q;
            mem_wdata_d = cmd_q[7:0];
            own_c1_d    = OWN_SPI;
        end else if (arb_gnt[OWN_HOST]) begin
            mem_en_d    = 1'b1;
            mem_we_d    = host_we;
            mem_addr_d  = host_addr;
            mem_wdata_d = host_wdata;
            own_c1_d    = OWN_HOST;
        end
        rd_c2_d       = mem_en_q & ~mem_we_q;
        own_c2_d      = own_c1_q;
        host_rvalid_d = rd_c2_q & (own_c2_q == OWN_HOST);
        host_rdata_d  = host_rvalid_d ? mem_rdata : host_rdata_q;
    end

    // State and pipeline registers; reset discards any in-flight read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rx_valid_q    <= 1'b0;
            rx_hist_q     <= 1'b0;
            rx_data_q     <= '0;
            cmd_q         <= '0;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            spi_err_q     <= 1'b0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            tx_cnt_q      <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            host_gnt_q    <= 1'b0;
            own_c1_q      <= OWN_SPI;
            rd_c2_q       <= 1'b0;
            own_c2_q      <= OWN_SPI;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_valid_q    <= rx_valid;
            rx_hist_q     <= rx_valid_q;
            rx_data_q     <= rx_data;
            cmd_q         <= cmd_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            spi_err_q     <= spi_err_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            tx_cnt_q      <= tx_cnt_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            host_gnt_q    <= host_gnt_d;
            own_c1_q      <= own_c1_d;
            rd_c2_q       <= rd_c2_d;
            own_c2_q      <= own_c2_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign host_gnt    = host_gnt_q;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign spi_err     = spi_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl. Cycle n is the period after the clock edge
// that first registers rx_valid high; inputs change and outputs are sampled
// on the falling edge. The RAM model returns addr^0x5A for never-written
// locations.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt;
    logic [7:0] host_rdata;
    logic       host_rvalid;
    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       spi_err;

    int checks = 0;
    int errors = 0;

    bit [7:0] ram [256];
    bit       written [256];

    always #5 clk = ~clk;

    spi_ram_ctrl #(.ADDR_SIZE(8), .TX_HOLD(9)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .spi_err     (spi_err)
    );

    // Synchronous single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we) begin
                ram[mem_addr]     <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr] ? ram[mem_addr] : (mem_addr ^ 8'h5A);
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spi_send(input logic [9:0] w);
        rx_data  = w;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_host_gnt"}, host_gnt, 0);
        chk({tag, "_host_rvalid"}, host_rvalid, 0);
        chk({tag, "_host_rdata"}, host_rdata, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_spi_err"}, spi_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_hi;
        int hn;
        int sn;
        logic [8:0] exp_h;

        rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Address set then SPI write AA <= 5C.
        spi_send(10'h0AA);
        @(negedge clk);
        spi_send(10'h15C);
        @(negedge clk);
        chk("wr_c1_mem_en", mem_en, 0);
        @(negedge clk);
        chk("wr_c2_mem_en", mem_en, 1);
        chk("wr_c2_mem_we", mem_we, 1);
        chk("wr_c2_mem_addr", mem_addr, 16'h00AA);
        chk("wr_c2_mem_wdata", mem_wdata, 16'h005C);
        @(negedge clk);
        chk("wr_c3_mem_en", mem_en, 0);
        @(negedge clk);
        chk("wr_c4_tx_valid", tx_valid, 0);
        chk("wr_ram_aa", ram[8'hAA], 16'h005C);
        repeat (2) @(negedge clk);

        // SPI read of AA: tx_valid for exactly 9 cycles from cycle 4.
        spi_send(10'h2AA);
        @(negedge clk);
        spi_send(10'h300);
        @(negedge clk);
        @(negedge clk);
        chk("rd_c2_mem_en", mem_en, 1);
        chk("rd_c2_mem_we", mem_we, 0);
        chk("rd_c2_mem_addr", mem_addr, 16'h00AA);
        @(negedge clk);
        chk("rd_c3_tx_valid", tx_valid, 0);
        n_hi = 0;
        for (int c = 4; c <= 16; c++) begin
            @(negedge clk);
            if (tx_valid) n_hi++;
            if (c == 4) begin
                chk("rd_c4_tx_valid", tx_valid, 1);
                chk("rd_c4_tx_data", tx_data, 16'h005C);
            end
            if (c == 13) chk("rd_c13_tx_valid", tx_valid, 0);
        end
        chk("rd_tx_hold_cycles", n_hi[15:0], 9);

        // First conflict after reset: SPI read wins, host read next cycle.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        spi_send(10'h300);
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
        @(negedge clk);
        chk("cf_c2_mem_en", mem_en, 1);
        chk("cf_c2_host_gnt", host_gnt, 0);
        chk("cf_c2_mem_addr", mem_addr, 16'h0000);
        @(negedge clk);
        chk("cf_c3_host_gnt", host_gnt, 1);
        chk("cf_c3_mem_addr", mem_addr, 16'h0040);
        chk("cf_c3_mem_we", mem_we, 0);
        host_req = 1'b0;
        @(negedge clk);
        chk("cf_c4_tx_valid", tx_valid, 1);
        chk("cf_c4_tx_data", tx_data, 16'h005A);
        chk("cf_c4_host_rvalid", host_rvalid, 0);
        @(negedge clk);
        chk("cf_c5_host_rvalid", host_rvalid, 1);
        chk("cf_c5_host_rdata", host_rdata, 16'h001A);
        @(negedge clk);
        chk("cf_c6_host_rvalid", host_rvalid, 0);
        repeat (12) @(negedge clk);

        // Continuous host writes with SPI writes every other cycle.
        spi_send(10'h010);
        repeat (3) @(negedge clk);
        exp_h = 9'b110101011;
        hn = 0;
        sn = 0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h90; host_wdata = 8'h30;
        rx_data = 10'h1A0; rx_valid = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            chk("rr_mem_en", mem_en, 1);
            chk("rr_mem_we", mem_we, 1);
            chk("rr_host_gnt", host_gnt, exp_h[k]);
            if (exp_h[k]) begin
                chk("rr_host_addr", mem_addr, 8'(8'h90 + hn));
                chk("rr_host_wdata", mem_wdata, 8'(8'h30 + hn));
                hn++;
            end else begin
                chk("rr_spi_addr", mem_addr, 16'h0010);
                chk("rr_spi_wdata", mem_wdata, 8'(8'hA0 + sn));
                sn++;
            end
            if (host_gnt) begin
                host_addr  = host_addr + 8'd1;
                host_wdata = host_wdata + 8'd1;
            end
            rx_valid = (k == 1 || k == 3);
            if (k == 1) rx_data = 10'h1A1;
            if (k == 3) rx_data = 10'h1A2;
        end
        host_req = 1'b0;
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Drop: second SPI word arrives while the first is still pending.
        spi_send(10'h177);
        repeat (5) @(negedge clk);
        rx_data = 10'h155; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("drop_c1_spi_err", spi_err, 0);
        rx_data = 10'h166; rx_valid = 1'b1;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'hC0; host_wdata = 8'hEE;
        @(negedge clk);
        chk("drop_c2_host_gnt", host_gnt, 1);
        chk("drop_c2_mem_wdata", mem_wdata, 16'h00EE);
        chk("drop_c2_spi_err", spi_err, 0);
        host_req = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("drop_c3_mem_en", mem_en, 1);
        chk("drop_c3_host_gnt", host_gnt, 0);
        chk("drop_c3_mem_wdata", mem_wdata, 16'h0055);
        chk("drop_c3_spi_err", spi_err, 1);
        for (int k = 4; k <= 8; k++) begin
            @(negedge clk);
            chk("drop_no_access", mem_en, 0);
        end
        chk("drop_spi_err_sticky", spi_err, 1);
        chk("drop_ram_10", ram[8'h10], 16'h0055);

        // Reset in C2 of an SPI read.
        spi_send(10'h233);
        @(negedge clk);
        spi_send(10'h300);
        @(negedge clk);
        @(negedge clk);
        chk("rst_c2_mem_en", mem_en, 1);
        chk("rst_c2_mem_addr", mem_addr, 16'h0033);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("rst");
        rst_n = 1'b1;
        n_hi = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (tx_valid || host_rvalid) n_hi++;
        end
        chk("rst_no_response", n_hi[15:0], 0);
        spi_send(10'h300);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_mem_addr", mem_addr, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_tx_valid", tx_valid, 1);
        chk("post_rst_tx_data", tx_data, 16'h005A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
